egress_frame_encap: RTL and testbench

//  Consumes transport packets (BTH-first, 256-bit words) from the outbound packet FIFO written by the egress

---
 rtl/egress_frame_encap.sv | 191 +++++++++++++++++++
 tb/tb_egress_frame_encap.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_frame_encap.sv
// Egress link framer: prepends a 16-byte link header to each transport packet
// and shifts the payload up by 16 bytes into 256-bit output words.
module egress_frame_encap #(
  parameter logic [15:0] ETHERTYPE = 16'h8915
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_outbound_pkt_empty,
  output logic         o_outbound_pkt_rd_en,
  input  logic [255:0] iv_outbound_pkt_data,
  input  logic [47:0]  iv_dst_mac,
  input  logic [47:0]  iv_src_mac,
  output logic         o_frame_valid,
  input  logic         i_frame_ready,
  output logic [255:0] ov_frame_data,
  output logic [31:0]  ov_frame_keep,
  output logic         o_frame_last,
  output logic         o_drop_pulse,
  output logic [31:0]  ov_frame_cnt
);

  typedef enum logic [1:0] {IDLE, BODY, TAIL} state_t;

  typedef struct packed {
    logic [13:0] len;    // transport packet length L
    logic [15:0] flen;   // frame length F = L + 16
    logic [8:0]  n_in;   // input words
    logic [8:0]  n_out;  // output words
  } dec_t;

  localparam logic [2:0] TR_UD = 3'b011;

  state_t        state_q, state_d;
  logic [127:0]  hold_q, hold_d;
  logic [8:0]    rem_q, rem_d;
  logic          tail_q, tail_d;
  logic [4:0]    fmod_q, fmod_d;
  logic          valid_q, valid_d;
  logic [255:0]  data_q, data_d;
  logic [31:0]   keep_q, keep_d;
  logic          last_q, last_d;
  logic          drop_q, drop_d;
  logic [31:0]   cnt_q, cnt_d;

  dec_t          dec;
  logic [7:0]    opc;
  logic [13:0]   plen;
  logic [127:0]  hdr;
  logic          advance, pop;
  logic [4:0]    fmod_sel;
  logic [31:0]   keep_last;

  // Length decode straight from the BTH/RETH fields of the FIFO head word.
  always_comb begin
    opc  = iv_outbound_pkt_data[31:24];
    plen = {1'b0, iv_outbound_pkt_data[94:88], iv_outbound_pkt_data[61:56]};
    dec  = '0;
    case (opc[4:0])
      5'h00, 5'h01, 5'h02, 5'h07, 5'h08, 5'h0E: dec.len = plen + 14'd12;
      5'h03, 5'h09, 5'h0D, 5'h0F, 5'h10:        dec.len = plen + 14'd16;
      5'h06, 5'h0A:                             dec.len = plen + 14'd28;
      5'h0B:                                    dec.len = plen + 14'd32;
      5'h04: dec.len = plen + ((opc[7:5] == TR_UD) ? 14'd28 : 14'd12);
      5'h05: dec.len = plen + ((opc[7:5] == TR_UD) ? 14'd32 : 14'd16);
      5'h0C:                                    dec.len = 14'd28;
      5'h13, 5'h14:                             dec.len = 14'd40;
      5'h11:                                    dec.len = 14'd16;
      default:                                  dec.len = 14'd0;
    endcase
    dec.flen  = {2'b00, dec.len} + 16'd16;
    dec.n_in  = dec.len[13:5]  + {8'd0, |dec.len[4:0]};
    dec.n_out = dec.flen[13:5] + {8'd0, |dec.flen[4:0]};
  end

  assign hdr      = {dec.flen, ETHERTYPE, iv_src_mac, iv_dst_mac};
  assign advance  = !valid_q || i_frame_ready;
  assign fmod_sel = (state_q == IDLE) ? dec.flen[4:0] : fmod_q;

  for (genvar i = 0; i < 32; i++) begin : g_keep
    assign keep_last[i] = (fmod_sel == 5'd0) || (5'(i) < fmod_sel);
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rem_d   = rem_q;
    tail_d  = tail_q;
    fmod_d  = fmod_q;
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    drop_d  = 1'b0;
    pop     = 1'b0;
    if (advance) begin
      valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (!i_outbound_pkt_empty) begin
            pop = 1'b1;
            if (dec.len == 14'd0) begin
              drop_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = {iv_outbound_pkt_data[127:0], hdr};
              hold_d  = iv_outbound_pkt_data[255:128];
              fmod_d  = dec.flen[4:0];
              tail_d  = dec.n_out > dec.n_in;
              rem_d   = dec.n_in - 9'd1;
              if (dec.n_out == 9'd1) begin
                last_d = 1'b1;
                keep_d = keep_last;
              end else begin
                last_d  = 1'b0;
                keep_d  = '1;
                state_d = (dec.n_in == 9'd1) ? TAIL : BODY;
              end
            end
          end
        end
        BODY: begin
          if (!i_outbound_pkt_empty) begin
            pop     = 1'b1;
            valid_d = 1'b1;
            data_d  = {iv_outbound_pkt_data[127:0], hold_q};
            hold_d  = iv_outbound_pkt_data[255:128];
            rem_d   = rem_q - 9'd1;
            last_d  = 1'b0;
            keep_d  = '1;
            if (rem_q == 9'd1) begin
              if (tail_q) begin
                state_d = TAIL;
              end else begin
                state_d = IDLE;
                last_d  = 1'b1;
                keep_d  = keep_last;
              end
            end
          end
        end
        TAIL: begin
          valid_d = 1'b1;
          data_d  = {128'd0, hold_q};
          last_d  = 1'b1;
          keep_d  = keep_last;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    cnt_d = cnt_q + {31'd0, valid_q & i_frame_ready & last_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rem_q   <= '0;
      tail_q  <= 1'b0;
      fmod_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rem_q   <= rem_d;
      tail_q  <= tail_d;
      fmod_q  <= fmod_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pop is combinational; held off during reset so every output reads 0.
  assign o_outbound_pkt_rd_en = pop && !rst;
  assign o_frame_valid        = valid_q;
  assign ov_frame_data        = data_q;
  assign ov_frame_keep        = keep_q;
  assign o_frame_last         = last_q;
  assign o_drop_pulse         = drop_q;
  assign ov_frame_cnt         = cnt_q;

endmodule

// File: tb/tb_egress_frame_encap.sv
// Bench for egress_frame_encap: FWFT FIFO model feeding the DUT and a byte-stream
// reference that predicts every framed word, keep, last and frame count.
module tb_egress_frame_encap;
  localparam logic [15:0] ETHERTYPE = 16'h8915;

  logic         clk = 1'b0;
  logic         rst;
  logic         empty, rd_en, valid, ready, flast, drop;
  logic [255:0] pkt_data, fdata;
  logic [47:0]  dst_mac, src_mac;
  logic [31:0]  fkeep, cnt;

  egress_frame_encap #(.ETHERTYPE(ETHERTYPE)) dut (
    .clk(clk), .rst(rst),
    .i_outbound_pkt_empty(empty), .o_outbound_pkt_rd_en(rd_en),
    .iv_outbound_pkt_data(pkt_data), .iv_dst_mac(dst_mac), .iv_src_mac(src_mac),
    .o_frame_valid(valid), .i_frame_ready(ready), .ov_frame_data(fdata),
    .ov_frame_keep(fkeep), .o_frame_last(flast), .o_drop_pulse(drop),
    .ov_frame_cnt(cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [255:0] data; logic [31:0] keep; logic last; } word_t;

  logic [255:0] fifo[$];
  word_t        exp_q[$];
  int errs = 0, checks = 0, exp_cnt = 0, exp_drops = 0, drops_seen = 0;
  bit           stalled = 0;
  logic [255:0] st_data;
  logic [31:0]  st_keep;
  logic         st_last;

  function automatic logic [255:0] rand256();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  function automatic int model_len(input logic [7:0] opc, input int p);
    int ud = (opc[7:5] == 3'b011) ? 16 : 0;
    case (opc[4:0])
      5'h00, 5'h01, 5'h02, 5'h07, 5'h08, 5'h0E: return p + 12;
      5'h03, 5'h09, 5'h0D, 5'h0F, 5'h10:        return p + 16;
      5'h06, 5'h0A:                             return p + 28;
      5'h0B:                                    return p + 32;
      5'h04:                                    return p + 12 + ud;
      5'h05:                                    return p + 16 + ud;
      5'h0C:                                    return 28;
      5'h13, 5'h14:                             return 40;
      5'h11:                                    return 16;
      default:                                  return 0;
    endcase
  endfunction

  // Queue the packet words and predict the frame as a flat byte stream.
  task automatic send_pkt(input logic [7:0] opc, input int p, output int no);
    int L, F, ni, nvalid;
    logic [255:0] w;
    logic [255:0] words[$];
    byte unsigned s[];
    word_t e;
    L  = model_len(opc, p);
    ni = (L == 0) ? 1 : (L + 31) / 32;
    for (int k = 0; k < ni; k++) begin
      w = rand256();
      if (k == 0) begin
        w[31:24] = opc; w[94:88] = p[12:6]; w[61:56] = p[5:0];
      end
      words.push_back(w);
      fifo.push_back(w);
    end
    no = 0;
    if (L == 0) begin exp_drops++; return; end
    F  = L + 16;
    no = (F + 31) / 32;
    s  = new[no * 32];
    for (int j = 0; j < 6; j++) begin
      s[j] = dst_mac[8*j +: 8]; s[6+j] = src_mac[8*j +: 8];
    end
    s[12] = ETHERTYPE[7:0]; s[13] = ETHERTYPE[15:8];
    s[14] = F[7:0];         s[15] = F[15:8];
    for (int k = 0; k < ni; k++)
      for (int j = 0; j < 32; j++)
        if (16 + 32*k + j < no*32) s[16 + 32*k + j] = words[k][8*j +: 8];
    nvalid = F - 32 * (no - 1);
    for (int k = 0; k < no; k++) begin
      for (int j = 0; j < 32; j++) begin
        e.data[8*j +: 8] = s[32*k + j];
        e.keep[j] = (k < no - 1) || (j < nvalid);
      end
      e.last = (k == no - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick(input bit rdy, input bit hole);
    bit pop, acc, lst;
    word_t e;
    empty    = hole || (fifo.size() == 0);
    pkt_data = (fifo.size() != 0) ? fifo[0] : '0;
    ready    = rdy;
    #1;
    checks++;
    if (rd_en === 1'b1 && empty) begin
      errs++; $display("FAIL pop_while_empty: rd_en=%b empty=%b", rd_en, empty);
    end
    if (stalled) begin
      checks++;
      if (valid !== 1'b1 || fdata !== st_data || fkeep !== st_keep || flast !== st_last) begin
        errs++;
        $display("FAIL stall_hold: valid=%b data=%h keep=%h last=%b, held data=%h keep=%h last=%b",
                 valid, fdata, fkeep, flast, st_data, st_keep, st_last);
      end
    end
    stalled = (valid === 1'b1) && !ready;
    st_data = fdata; st_keep = fkeep; st_last = flast;
    pop = (rd_en === 1'b1) && !empty;
    acc = (valid === 1'b1) && ready;
    lst = flast;
    if (drop === 1'b1) drops_seen++;
    if (acc) begin
      checks++;
      if (exp_q.size() == 0) begin
        errs++; $display("FAIL unexpected_word: data=%h keep=%h last=%b", fdata, fkeep, flast);
      end else begin
        e = exp_q.pop_front();
        if (fdata !== e.data || fkeep !== e.keep || flast !== e.last) begin
          errs++;
          $display("FAIL word: got data=%h keep=%h last=%b, want data=%h keep=%h last=%b",
                   fdata, fkeep, flast, e.data, e.keep, e.last);
        end
      end
    end
    @(posedge clk); #1;
    if (pop) void'(fifo.pop_front());
    if (acc && lst) begin
      exp_cnt++;
      checks++;
      if (cnt !== 32'(exp_cnt)) begin
        errs++; $display("FAIL frame_cnt: got %0d want %0d", cnt, exp_cnt);
      end
    end
  endtask

  // mode 0: ready high, 1: ready 1010.., 2: random ready and random FIFO holes
  task automatic run(input int mode, input int gap_at, input int budget, output int cycles);
    bit rdy, hole;
    cycles = 0;
    while ((exp_q.size() != 0 || fifo.size() != 0) && cycles < budget) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles % 2 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      hole = (gap_at >= 0 && cycles >= gap_at && cycles < gap_at + 5) ||
             (mode == 2 && $urandom_range(0, 4) == 0);
      if (gap_at >= 0 && cycles > gap_at && cycles < gap_at + 5) begin
        checks++;
        if (valid !== 1'b0) begin
          errs++; $display("FAIL gap_valid: valid=%b want 0 at cycle %0d", valid, cycles);
        end
      end
      tick(rdy, hole);
      cycles++;
    end
    checks++;
    if (exp_q.size() != 0 || fifo.size() != 0) begin
      errs++;
      $display("FAIL timeout: %0d words pending, %0d fifo words left", exp_q.size(), fifo.size());
    end
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  task automatic new_macs();
    dst_mac = {16'($urandom), $urandom};
    src_mac = {16'($urandom), $urandom};
  endtask

  task automatic check_cycles(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errs++; $display("FAIL %s cycles: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (valid !== 1'b0 || fdata !== '0 || fkeep !== '0 || flast !== 1'b0 ||
        drop !== 1'b0 || cnt !== '0 || rd_en !== 1'b0) begin
      errs++;
      $display("FAIL %s: valid=%b data=%h keep=%h last=%b drop=%b cnt=%0d rd_en=%b, want all 0",
               name, valid, fdata, fkeep, flast, drop, cnt, rd_en);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_ack();
    int no, cyc;
    new_macs();
    send_pkt(8'h11, int'($urandom_range(0, 8191)), no);
    run(0, -1, 50, cyc);
    check_cycles("ack", cyc, no + 1);
  endtask

  task automatic test_send_only();
    int no, cyc;
    new_macs();
    send_pkt(8'h04, 20, no);
    run(0, -1, 50, cyc);
    check_cycles("send_only", cyc, no + 1);
  endtask

  task automatic test_write_first();
    int no, cyc;
    new_macs();
    send_pkt(8'h06, 1024, no);
    run(0, -1, 200, cyc);
    check_cycles("write_first", cyc, no + 1);
  endtask

  task automatic test_stall();
    int no, cyc;
    new_macs();
    send_pkt(8'h06, 1024, no);
    run(1, -1, 400, cyc);
  endtask

  task automatic test_drop();
    int no, cyc;
    new_macs();
    drops_seen = 0; exp_drops = 0;
    send_pkt(8'h12, 100, no);
    send_pkt(8'h11, 0, no);
    run(0, -1, 50, cyc);
    checks++;
    if (drops_seen != exp_drops) begin
      errs++; $display("FAIL drop_pulse: got %0d pulses want %0d", drops_seen, exp_drops);
    end
  endtask

  task automatic test_gap();
    int no, cyc;
    new_macs();
    send_pkt(8'h06, 1024, no);
    run(0, 5, 200, cyc);
    check_cycles("gap", cyc, no + 1 + 5);
  endtask

  task automatic test_back_to_back();
    int no, cyc, total;
    int ps[6] = '{20, 52, 4, 5, 0, 36};
    new_macs();
    total = 0;
    foreach (ps[i]) begin
      send_pkt(8'h00, ps[i], no);
      total += no;
    end
    run(0, -1, 200, cyc);
    check_cycles("back_to_back", cyc, total + 1);
  endtask

  task automatic test_random();
    int no, cyc;
    logic [7:0] ops[17] = '{8'h04, 8'h64, 8'h65, 8'h00, 8'h01, 8'h02, 8'h03, 8'h06, 8'h0A,
                            8'h0B, 8'h0C, 8'h0D, 8'h10, 8'h11, 8'h14, 8'h12, 8'h1F};
    new_macs();
    drops_seen = 0; exp_drops = 0;
    for (int i = 0; i < 24; i++)
      send_pkt(ops[$urandom_range(0, 16)], int'($urandom_range(0, 200)), no);
    run(2, -1, 5000, cyc);
    checks++;
    if (drops_seen != exp_drops) begin
      errs++; $display("FAIL random_drops: got %0d pulses want %0d", drops_seen, exp_drops);
    end
  endtask

  task automatic test_reset_mid();
    int no, cyc;
    new_macs();
    send_pkt(8'h06, 1024, no);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_idle_outputs("reset_mid_frame");
    fifo.delete(); exp_q.delete();
    stalled = 0; exp_cnt = 0;
    empty = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("reset_held");
    rst = 1'b0;
    send_pkt(8'h11, 7, no);
    run(0, -1, 50, cyc);
    check_cycles("after_reset", cyc, no + 1);
  endtask

  initial begin
    rst = 1'b1; empty = 1'b1; ready = 1'b0; pkt_data = '0;
    dst_mac = '0; src_mac = '0;
    test_reset();
    test_ack();
    test_send_only();
    test_write_first();
    test_stall();
    test_drop();
    test_gap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
